// File: rtl/sdr_tx_pkg.sv
// sdr_tx_pkg: shared FSM type, default patterns and oe timing limits for the sdr transmit path.
package sdr_tx_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LEAD,
        ST_DATA,
        ST_TAIL,
        ST_TRAIN
    } state_t;

    localparam logic [7:0] DEF_IDLE_PATTERN  = 8'h00;
    localparam logic [7:0] DEF_TRAIN_PATTERN = 8'hA5;
    localparam int         DEF_OE_LEAD       = 2;
    localparam int         DEF_OE_TAIL       = 2;

    // The lead/tail counters are 4 bits wide, and at least one lead cycle is needed for turnaround.
    function automatic bit oe_cfg_ok(input int lead, input int tail);
        return (lead >= 1) && (lead <= 15) && (tail >= 0) && (tail <= 15);
    endfunction

endpackage

// File: rtl/sdr_tx_fifo2.sv
// sdr_tx_fifo2: 2-entry skid FIFO between the beat interface and the pad output register.
module sdr_tx_fifo2 #(
    parameter int WIDTH = 8
) (
    input  logic             i_sclk,
    input  logic             i_rst_n,
    input  logic             i_push,
    input  logic [WIDTH-1:0] i_data,
    input  logic             i_pop,
    output logic [WIDTH-1:0] o_head,
    output logic [1:0]       o_count
);

    logic [WIDTH-1:0] r_mem [2];
    logic             r_wr;
    logic             r_rd;
    logic [1:0]       r_count;
    logic             w_push;
    logic             w_pop;

    assign w_push  = i_push && (r_count != 2'd2);
    assign w_pop   = i_pop && (r_count != 2'd0);
    assign o_head  = r_mem[r_rd];
    assign o_count = r_count;

    always_ff @(posedge i_sclk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_wr    <= 1'b0;
            r_rd    <= 1'b0;
            r_count <= 2'd0;
        end else begin
            r_wr    <= r_wr ^ w_push;
            r_rd    <= r_rd ^ w_pop;
            r_count <= r_count + {1'b0, w_push} - {1'b0, w_pop};
        end
    end

    // Payload needs no reset; a reset empties the FIFO through the pointers and count.
    always_ff @(posedge i_sclk) begin
        if (w_push) r_mem[r_wr] <= i_data;
    end

endmodule

// File: rtl/sdr_tx.sv
// sdr_tx: single-data-rate transmit path with oe turnaround and true/inverted training bursts.
// q and oe come straight from flops so they can pack into the IO output registers.
module sdr_tx
    import sdr_tx_pkg::*;
#(
    parameter int               WIDTH         = 8,
    parameter logic [WIDTH-1:0] IDLE_PATTERN  = WIDTH'(DEF_IDLE_PATTERN),
    parameter logic [WIDTH-1:0] TRAIN_PATTERN = WIDTH'(DEF_TRAIN_PATTERN),
    parameter int               OE_LEAD       = DEF_OE_LEAD,
    parameter int               OE_TAIL       = DEF_OE_TAIL
) (
    input  logic             i_sclk,
    input  logic             i_rst_n,
    input  logic [WIDTH-1:0] i_tx_data,
    input  logic             i_tx_valid,
    output logic             o_tx_ready,
    input  logic             i_train_req,
    input  logic [7:0]       i_train_len,
    output logic             o_train_done,
    output logic             o_busy,
    output logic [WIDTH-1:0] o_q,
    output logic             o_oe
);

    localparam logic [3:0] LEAD_N = 4'(OE_LEAD);
    localparam logic [3:0] TAIL_N = 4'(OE_TAIL);

    if (!oe_cfg_ok(OE_LEAD, OE_TAIL)) begin : g_bad_oe_cfg
        $fatal(1, "sdr_tx: OE_LEAD must be 1..15 and OE_TAIL 0..15");
    end

    state_t           r_state;
    state_t           w_next;
    logic [3:0]       r_cnt;
    logic [3:0]       w_cnt;
    logic [7:0]       r_tcnt;
    logic [7:0]       w_tcnt;
    logic [7:0]       r_tlen;
    logic [7:0]       w_tlen;
    logic [7:0]       w_tidx;
    logic             w_tbeat;
    logic             r_pending;
    logic             w_pending;
    logic             r_run;
    logic             w_train;
    logic             w_fifo_ne;
    logic [1:0]       w_count;
    logic [WIDTH-1:0] w_head;
    logic             w_push;
    logic             w_pop;
    logic [WIDTH-1:0] w_q;
    logic             w_oe;
    logic             w_done;
    logic [WIDTH-1:0] r_q;
    logic             r_oe;
    logic             r_done;

    // r_run keeps tx_ready low until the first edge after reset release.
    assign o_tx_ready   = r_run && (w_count != 2'd2) && (r_state != ST_TRAIN) && !r_pending;
    assign o_busy       = (r_state != ST_IDLE) || w_fifo_ne;
    assign o_q          = r_q;
    assign o_oe         = r_oe;
    assign o_train_done = r_done;
    assign w_push       = i_tx_valid && o_tx_ready;
    assign w_fifo_ne    = (w_count != 2'd0);
    assign w_train      = i_train_req || r_pending;

    sdr_tx_fifo2 #(.WIDTH(WIDTH)) u_fifo (
        .i_sclk  (i_sclk),
        .i_rst_n (i_rst_n),
        .i_push  (w_push),
        .i_data  (i_tx_data),
        .i_pop   (w_pop),
        .o_head  (w_head),
        .o_count (w_count)
    );

    always_ff @(posedge i_sclk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state   <= ST_IDLE;
            r_cnt     <= 4'd0;
            r_tcnt    <= 8'd0;
            r_tlen    <= 8'd0;
            r_pending <= 1'b0;
            r_run     <= 1'b0;
        end else begin
            r_state   <= w_next;
            r_cnt     <= w_cnt;
            r_tcnt    <= w_tcnt;
            r_tlen    <= w_tlen;
            r_pending <= w_pending;
            r_run     <= 1'b1;
        end
    end

    // r_cnt counts lead/tail cycles already driven; r_tcnt counts training beats already driven.
    always_comb begin
        w_tidx = (r_state == ST_TRAIN) ? r_tcnt : 8'd0;
        w_tlen = (r_state == ST_TRAIN) ? r_tlen : i_train_len;
        w_next = r_state;
        case (r_state)
            ST_IDLE:  w_next = w_train ? ST_TRAIN : (w_fifo_ne ? ST_LEAD : ST_IDLE);
            ST_LEAD:  w_next = (r_cnt == LEAD_N) ? ST_DATA : ST_LEAD;
            ST_DATA:  w_next = w_fifo_ne ? ST_DATA : ((OE_TAIL == 0) ? ST_IDLE : ST_TAIL);
            ST_TAIL:  w_next = w_fifo_ne ? ST_DATA : ((r_cnt == TAIL_N) ? ST_IDLE : ST_TAIL);
            ST_TRAIN: w_next = (r_tcnt == r_tlen) ? ST_IDLE : ST_TRAIN;
            default:  w_next = ST_IDLE;
        endcase
        w_tbeat   = (w_next == ST_TRAIN) && (w_tidx != w_tlen);
        w_tcnt    = w_tidx + 8'(w_tbeat);
        w_cnt     = (w_next != r_state) ? 4'd1 :
                    ((w_next == ST_LEAD) || (w_next == ST_TAIL)) ? r_cnt + 4'd1 : r_cnt;
        w_pending = (r_pending || (i_train_req && (r_state != ST_IDLE) && (r_state != ST_TRAIN)))
                    && (w_next != ST_TRAIN);
    end

    always_comb begin
        w_pop  = w_fifo_ne && (w_next == ST_DATA);
        w_oe   = (w_next != ST_IDLE);
        w_done = (r_state == ST_TRAIN) && (w_next == ST_IDLE);
        w_q    = w_pop ? w_head :
                 w_tbeat ? (w_tidx[0] ? ~TRAIN_PATTERN : TRAIN_PATTERN) : IDLE_PATTERN;
    end

    always_ff @(posedge i_sclk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_q    <= IDLE_PATTERN;
            r_oe   <= 1'b0;
            r_done <= 1'b0;
        end else begin
            r_q    <= w_q;
            r_oe   <= w_oe;
            r_done <= w_done;
        end
    end

endmodule

// File: tb/tb_sdr_tx.sv
// tb_sdr_tx: directed bench for sdr_tx; accepted beats go into a queue and are matched against q.
module tb_sdr_tx;

    logic       clk       = 1'b0;
    logic       rst_n     = 1'b1;
    logic [7:0] tx_data   = 8'h00;
    logic       tx_valid  = 1'b0;
    logic       train_req = 1'b0;
    logic [7:0] train_len = 8'h00;
    logic       tx_ready;
    logic       train_done;
    logic       busy;
    logic [7:0] q;
    logic       oe;

    int         n_assert = 0;
    int         n_fail   = 0;
    int         n_push   = 0;
    int         n_pop    = 0;
    int         tbeats   = 0;
    bit         pushed;
    bit         popped;
    logic [7:0] sb [$];

    sdr_tx dut (
        .i_sclk       (clk),
        .i_rst_n      (rst_n),
        .i_tx_data    (tx_data),
        .i_tx_valid   (tx_valid),
        .o_tx_ready   (tx_ready),
        .i_train_req  (train_req),
        .i_train_len  (train_len),
        .o_train_done (train_done),
        .o_busy       (busy),
        .o_q          (q),
        .o_oe         (oe)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
        n_assert++;
        assert (got === want) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, got, want);
        end
    endtask

    // One sclk: log the transfer the coming edge will make, then check q at the falling edge.
    task automatic cyc();
        logic [7:0] w;
        pushed = tx_valid && tx_ready && rst_n;
        if (pushed) begin
            sb.push_back(tx_data);
            n_push++;
        end
        @(posedge clk);
        @(negedge clk);
        popped = 1'b0;
        if (!oe) chk("q_idle_while_oe_off", q, 8'h00);
        else if (q == 8'hA5 || q == 8'h5A) begin
            tbeats++;
            chk("fifo_drained_before_train", sb.size(), 0);
        end else if (q != 8'h00) begin
            if (sb.size() == 0) chk("unexpected_beat", q, 8'h00);
            else begin
                w = sb.pop_front();
                chk("sb_data", q, w);
                popped = 1'b1;
                n_pop++;
            end
        end
    endtask

    task automatic wait_idle(input string tag);
        int k = 0;
        while (busy && k < 50) begin
            cyc();
            k++;
        end
        chk(tag, busy, 0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0] pat [4];
        int  sent, cnt, first, last, k0, blocked_push;
        bit  rdy_drop, seen;
        pat = '{8'hA5, 8'h5A, 8'hA5, 8'h5A};

        // reset held with inputs toggling
        #1 rst_n = 1'b0;
        tx_valid  = 1'b1;
        train_req = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tx_data = 8'h11 * 8'(i + 1);
            cyc();
            chk("rst_q", q, 8'h00);
            chk("rst_oe", oe, 0);
            chk("rst_ready", tx_ready, 0);
            chk("rst_busy", busy, 0);
            chk("rst_done", train_done, 0);
        end
        rst_n     = 1'b1;
        tx_valid  = 1'b0;
        train_req = 1'b0;
        cyc();
        chk("rel_ready", tx_ready, 1);
        chk("rel_oe", oe, 0);
        chk("rel_busy", busy, 0);

        // single beat from IDLE
        tx_data  = 8'h3C;
        tx_valid = 1'b1;
        cyc();
        tx_valid = 1'b0;
        chk("t2_busy_n", busy, 1);
        chk("t2_oe_n", oe, 0);
        cyc();
        chk("t2_oe_n1", oe, 1);
        chk("t2_q_n1", q, 8'h00);
        cyc();
        chk("t2_oe_n2", oe, 1);
        chk("t2_q_n2", q, 8'h00);
        cyc();
        chk("t2_q_n3", q, 8'h3C);
        chk("t2_pop_n3", popped, 1);
        cyc();
        cyc();
        chk("t2_oe_n5", oe, 1);
        chk("t2_q_n5", q, 8'h00);
        cyc();
        chk("t2_oe_n6", oe, 0);
        chk("t2_busy_n6", busy, 0);

        // 16-beat continuous stream
        sent = 0; cnt = 0; first = -1; last = -1; k0 = -1; rdy_drop = 1'b0;
        tx_data  = 8'h40;
        tx_valid = 1'b1;
        for (int k = 0; k < 60 && cnt < 16; k++) begin
            cyc();
            if (pushed) begin
                if (k0 < 0) k0 = k;
                sent++;
                tx_data  = 8'h40 + 8'(sent);
                tx_valid = (sent < 16);
            end
            if (popped) begin
                if (first < 0) first = k;
                last = k;
                cnt++;
            end
            if (first >= 0 && tx_valid && !tx_ready) rdy_drop = 1'b1;
        end
        chk("t3_beats", cnt, 16);
        chk("t3_latency", first - k0, 3);
        chk("t3_no_bubble", last - first, 15);
        chk("t3_ready_held", rdy_drop, 0);
        wait_idle("t3_idle");

        // training request mid-stream with valid held
        sent = 0; cnt = 0;
        tx_data  = 8'h60;
        tx_valid = 1'b1;
        for (int k = 0; k < 20 && cnt < 3; k++) begin
            cyc();
            if (pushed) begin
                sent++;
                tx_data = 8'h60 + 8'(sent);
            end
            if (popped) cnt++;
        end
        chk("t4_streaming", cnt, 3);
        train_req = 1'b1;
        train_len = 8'd4;
        tbeats    = 0;
        cyc();
        train_req = 1'b0;
        if (pushed) begin
            sent++;
            tx_data = 8'h60 + 8'(sent);
        end
        chk("t4_ready_blocked", tx_ready, 0);
        blocked_push = 0;
        seen = 1'b0;
        for (int k = 0; k < 40 && !seen; k++) begin
            cyc();
            if (pushed) blocked_push++;
            seen = train_done;
        end
        chk("t4_done_seen", seen, 1);
        chk("t4_no_push_blocked", blocked_push, 0);
        chk("t4_train_beats", tbeats, 4);
        chk("t4_fifo_empty", sb.size(), 0);
        for (int k = 0; k < 30 && sent < 8; k++) begin
            cyc();
            if (pushed) begin
                sent++;
                tx_data = 8'h60 + 8'(sent);
            end
        end
        tx_valid = 1'b0;
        chk("t4_resumed", sent, 8);
        wait_idle("t4_idle");
        chk("t4_none_lost", n_pop, n_push);

        // training burst of 4, then zero-length burst
        train_req = 1'b1;
        train_len = 8'd4;
        tbeats    = 0;
        cyc();
        train_req = 1'b0;
        chk("t5_ready_train", tx_ready, 0);
        for (int j = 0; j < 4; j++) begin
            chk("t5_q", q, pat[j]);
            chk("t5_oe", oe, 1);
            chk("t5_done_early", train_done, 0);
            cyc();
        end
        chk("t5_done", train_done, 1);
        chk("t5_oe_off", oe, 0);
        chk("t5_q_idle", q, 8'h00);
        cyc();
        chk("t5_done_pulse", train_done, 0);
        chk("t5_ready_after", tx_ready, 1);
        chk("t5_beats", tbeats, 4);
        train_req = 1'b1;
        train_len = 8'd0;
        cyc();
        train_req = 1'b0;
        chk("t5z_q", q, 8'h00);
        chk("t5z_done0", train_done, 0);
        cyc();
        chk("t5z_done", train_done, 1);
        cyc();
        chk("t5z_pulse", train_done, 0);
        chk("t5z_beats", tbeats, 4);

        // reset asserted while data is on the pads
        sent = 0;
        seen = 1'b0;
        tx_data  = 8'h71;
        tx_valid = 1'b1;
        for (int k = 0; k < 20 && !seen; k++) begin
            cyc();
            if (pushed) begin
                sent++;
                tx_data = 8'h71 + 8'(sent);
            end
            seen = popped;
        end
        chk("t6_in_data", seen, 1);
        chk("t6_busy_before", busy, 1);
        #2 rst_n = 1'b0;
        #1;
        chk("t6_oe_async", oe, 0);
        chk("t6_q_async", q, 8'h00);
        chk("t6_ready_rst", tx_ready, 0);
        chk("t6_busy_rst", busy, 0);
        sb.delete();
        cyc();
        cyc();
        chk("t6_no_done", train_done, 0);
        rst_n    = 1'b1;
        tx_valid = 1'b0;
        cyc();
        chk("t6_busy_after", busy, 0);
        chk("t6_ready_after", tx_ready, 1);
        tx_data  = 8'h77;
        tx_valid = 1'b1;
        cyc();
        tx_valid = 1'b0;
        chk("t6_oe_m", oe, 0);
        cyc();
        chk("t6_oe_m1", oe, 1);
        chk("t6_q_m1", q, 8'h00);
        cyc();
        chk("t6_oe_m2", oe, 1);
        chk("t6_q_m2", q, 8'h00);
        cyc();
        chk("t6_q_m3", q, 8'h77);
        wait_idle("t6_idle");

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
